qerv_dbus_if: RTL

Data-bus interface stage directly downstream of the buffer register. It takes the word-aligned address and byte offset computed there, collects serial store data from rs2, runs one Wishbone-style classic bus cycle, and returns load data serially to the register file. Load data is aligned, and sign- or zero-extended. Processing runs BITS_PER_CYCLE bits per cycle.

---
 rtl/qerv_dbus_if_if.sv | 13 +
 rtl/qerv_dbus_if.sv | 122 ++++++++++++
 2 files changed

// File: rtl/qerv_dbus_if_if.sv
// Wishbone-style classic data bus between qerv_dbus_if (master) and memory (slave).
interface qerv_dbus_if_if;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic [31:0] rdt;
  logic        ack;

  modport master (output adr, dat, sel, we, cyc, input rdt, ack);
  modport slave  (input adr, dat, sel, we, cyc, output rdt, ack);
endinterface

// File: rtl/qerv_dbus_if.sv
// Data-bus stage: collects serial store data, runs one classic bus cycle and
// returns aligned, sign/zero-extended load data serially.
module qerv_dbus_if #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_cnt_en,
  input  logic [4:0]                i_cnt,
  input  logic                      i_mem_op,
  input  logic                      i_store,
  input  logic                      i_signed,
  input  logic                      i_word,
  input  logic                      i_half,
  input  logic [1:0]                i_lsb,
  input  logic [31:0]               i_adr,
  input  logic [BITS_PER_CYCLE-1:0] i_rs2,
  input  logic                      i_dbus_req,
  qerv_dbus_if_if.master            dbus,
  output logic [BITS_PER_CYCLE-1:0] o_rd,
  output logic                      o_misalign,
  output logic                      o_done
);

  typedef enum logic {IDLE, BUS} state_t;

  state_t                    state, state_nxt;
  logic [31:0]               adr, dat, rdt_sh;
  logic                      we, sign_r;
  logic                      start, finish, shift_en, serial;
  logic [BITS_PER_CYCLE-1:0] shift_in;
  logic [5:0]                width, idx;
  logic                      unused_adr_lsb;

  assign unused_adr_lsb = ^i_adr[1:0];

  assign o_misalign = i_mem_op & ((i_word & |i_lsb) | (i_half & i_lsb[0]));

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: if (i_dbus_req && !o_misalign) begin
        state_nxt = BUS;
        start     = 1'b1;
      end
      BUS: if (dbus.ack) begin
        state_nxt = IDLE;
        finish    = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      adr    <= '0;
      we     <= 1'b0;
      o_done <= 1'b0;
    end else begin
      state  <= state_nxt;
      o_done <= finish;
      if (start) begin
        adr <= {i_adr[31:2], 2'b00};
        we  <= i_store;
      end else if (finish) begin
        we  <= 1'b0;
      end
    end
  end

  assign shift_en = (state == IDLE) & i_cnt_en & i_mem_op;
  assign shift_in = i_store ? i_rs2 : '0;
  assign rdt_sh   = dbus.rdt >> {i_lsb, 3'b000};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dat    <= '0;
      sign_r <= 1'b0;
    end else if (shift_en) begin
      dat <= {shift_in, dat[31:BITS_PER_CYCLE]};
    end else if (finish && !i_store) begin
      dat    <= rdt_sh;
      sign_r <= i_word ? rdt_sh[31] : (i_half ? rdt_sh[15] : rdt_sh[7]);
    end
  end

  assign dbus.adr = adr;
  assign dbus.we  = we;
  assign dbus.cyc = (state == BUS);

  always_comb begin
    if (i_word) begin
      dbus.sel = 4'b1111;
      dbus.dat = dat;
    end else if (i_half) begin
      dbus.sel = i_lsb[1] ? 4'b1100 : 4'b0011;
      dbus.dat = {dat[15:0], dat[15:0]};
    end else begin
      dbus.sel = 4'b0001 << i_lsb;
      dbus.dat = {4{dat[7:0]}};
    end
  end

  // Bits past the access width come from the latched sign (or zero for unsigned).
  assign serial = i_cnt_en & i_mem_op & ~i_store & (state == IDLE);
  assign width  = i_word ? 6'd32 : (i_half ? 6'd16 : 6'd8);

  always_comb begin
    o_rd = '0;
    idx  = '0;
    if (serial) begin
      for (int unsigned k = 0; k < BITS_PER_CYCLE; k++) begin
        idx     = {1'b0, i_cnt} + 6'(k);
        o_rd[k] = (idx < width) ? dat[k] : (i_signed & sign_r);
      end
    end
  end

endmodule
